timing_gen: RTL
===============

Name: timing_gen

Overview:
- Machine-cycle/beat timing generator for the hardwired controller.
- Produces the W1/W2/W3 machine-cycle levels and the T1/T2/T3 beat pulses that the controller consumes.
- Consumes the controller's SHORT/LONG/STOP requests and the front-panel start button QD.
- Sits between the board clock and the controller; it is the driving end of the w1/w2/w3/t3 and short/long/stop interface.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the QD synchronizer (minimum 2).
- BEAT_CLKS, 1, clk cycles per beat (1..255); lets a slow panel clock be stretched.

Ports:
- clk  input  1  system clock; all state on rising edge.
- clr  input  1  asynchronous active-low reset.
- qd  input  1  raw start/continue button, asynchronous, active-high.
- short  input  1  from controller: instruction ends after W1.
- long  input  1  from controller: insert W3 after W2.
- stop  input  1  from controller: halt after current machine cycle.
- w1  output  1  machine cycle 1 level.
- w2  output  1  machine cycle 2 level.
- w3  output  1  machine cycle 3 level.
- t1  output  1  beat 1 pulse.
- t2  output  1  beat 2 pulse.
- t3  output  1  beat 3 pulse; the controller latches st0 on its falling edge.
- running  output  1  generator is sequencing beats.

Behaviour:
- Reset (clr=0, immediate, mid-operation included): W=W1, beat=T1, beat counter=0, running=0. Outputs: w1=1, w2=0, w3=0, t1=t2=t3=0, running=0.
- Exactly one of w1/w2/w3 is high at all times, including while halted. W1 stays visible so the controller's panel-mode decode is valid while halted.
- t1/t2/t3 are all 0 when running=0. When running=1, exactly one is high: t1 = running && beat==T1, and likewise for t2 and t3.
- Each beat lasts BEAT_CLKS clk cycles; the beat counter counts 0..BEAT_CLKS-1 and then advances the beat T1 -> T2 -> T3.
- Last clk of T3 is the decision point. short/long/stop are sampled only there and ignored elsewhere.
  - W1: short=1 -> next W1; else -> W2. long is ignored in W1.
  - W2: long=1 -> next W3; else -> W1. short is ignored in W2.
  - W3: always -> W1.
  - When both short and long are high in W1, short wins.
- stop=1 at the decision point:
  - The W transition above still occurs.
  - beat returns to T1 and running <= 0, so the next W is presented with no beats.
- Start: qd is synchronized through SYNC_STAGES flops and rising-edge detected (qd_pulse, 1 clk).
  - qd_pulse while running=0 -> running <= 1 and beat=T1; t1 rises on the following clk edge.
  - qd_pulse while running=1 is ignored.
  - qd_pulse on the same clk as a stop decision -> stop wins and the generator halts; a new press is required.
- Latency: qd edge to running=1 is SYNC_STAGES+1 clk. running=1 to first t1 is 0 clk (t1 is combinational from state).
- All outputs are registered-state decodes; no combinational path from short/long/stop to any output.

Optional Feature:
- Macro TIMING_GEN_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - step=1 at any decision point is treated as stop=1, so the generator halts after every machine cycle and needs one QD press per cycle.
  - step is sampled with the same rules as stop.
- Undefined: the port is absent and the generator halts only on stop.

Decomposition:
- Package timing_pkg:
  - enum w_state_t {W_1, W_2, W_3}.
  - enum beat_t {T_1, T_2, T_3}.
  - function next_w(w_state_t, short, long) implementing the transition rules.
- Sub-module qd_sync (parameter SYNC_STAGES): clk, clr, async in -> synchronized level plus 1-clk rising-edge pulse. Reset clears all stages to 0.

Test Plan:
- Reset then hold: clr=0 for 3 clk, release -> w1=1, t1..t3=0, running=0 indefinitely with qd=0.
- Short instruction: press qd, short=1 at every T3, stop=0, BEAT_CLKS=1 -> repeating t1,t2,t3 with w1 always high; 9 clk gives 3 full W1 cycles.
- Long instruction (LD/ST path): short=0, long=1 -> sequence W1,W2,W3,W1, each 3 clk; w2 and w3 each high exactly 3 clk.
- Stop mid-program: stop=1 at W2 T3 with long=0 -> next state W1 with running=0; w1=1, t1..t3=0; press qd -> t1 rises SYNC_STAGES+1 clk later.
- Simultaneous/ignored events: qd pulse while running -> no change; qd pulse coinciding with the stop decision -> halted; clr=0 asserted during W3 T2 -> immediate return to W1, running=0.
- BEAT_CLKS=4 with TIMING_GEN_STEP_EN and step=1 -> each beat is 4 clk wide; halts after every machine cycle; 3 qd presses walk W1 -> W2 -> W3 -> W1 with long=1.

Source files
------------

// File: rtl/timing_pkg.sv
// timing_pkg: machine-cycle and beat encodings plus the W transition rule for timing_gen.
package timing_pkg;
   typedef enum logic [1:0] {W_1, W_2, W_3} w_state_t;
   typedef enum logic [1:0] {T_1, T_2, T_3} beat_t;
   function automatic w_state_t next_w(input w_state_t w, input logic short, input logic long);
      return (w == W_1) ? (short ? W_1 : W_2) : (w == W_2) ? (long ? W_3 : W_1) : W_1;
   endfunction
endpackage

// File: rtl/timing_gen_qd_sync.sv
// qd_sync: multi-flop synchronizer for the start button with a 1-clk rising-edge pulse.
module qd_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic clr,
   input  logic i_async,
   output logic o_level,
   output logic o_pulse
);
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end
   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;
endmodule

// File: rtl/timing_gen.sv
// timing_gen: W1/W2/W3 machine-cycle and T1/T2/T3 beat generator for the hardwired controller.
// Optional TIMING_GEN_STEP_EN adds a step input that halts after every machine cycle.
module timing_gen #(
   parameter int SYNC_STAGES = 2,
   parameter int BEAT_CLKS   = 1
) (
   input  logic clk,
   input  logic clr,
   input  logic qd,
   input  logic short,
   input  logic long,
   input  logic stop,
`ifdef TIMING_GEN_STEP_EN
   input  logic step,
`endif
   output logic w1,
   output logic w2,
   output logic w3,
   output logic t1,
   output logic t2,
   output logic t3,
   output logic running
);
   import timing_pkg::*;
   w_state_t   r_w, w_w_nxt;
   beat_t      r_beat, w_beat_nxt;
   logic [7:0] r_cnt, w_cnt_nxt;
   logic       r_running, w_run_nxt;
   logic       w_qd_level, w_qd_pulse, w_last, w_dec, w_halt;
   qd_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .clr     (clr),
      .i_async (qd),
      .o_level (w_qd_level),
      .o_pulse (w_qd_pulse)
   );
`ifdef TIMING_GEN_STEP_EN
   assign w_halt = stop | step;
`else
   assign w_halt = stop;
`endif
   assign w_last = r_cnt == 8'(BEAT_CLKS - 1);
   // short/long/halt only matter on the last clk of T3
   assign w_dec  = r_running && r_beat == T_3 && w_last;
   always_comb begin
      w_w_nxt    = r_w;
      w_beat_nxt = r_beat;
      w_cnt_nxt  = r_cnt;
      w_run_nxt  = r_running;
      if (!r_running) begin
         if (w_qd_pulse && w_qd_level) begin
            w_run_nxt  = 1'b1;
            w_beat_nxt = T_1;
            w_cnt_nxt  = '0;
         end
      end else if (!w_last) begin
         w_cnt_nxt = r_cnt + 8'd1;
      end else begin
         w_cnt_nxt  = '0;
         w_beat_nxt = (r_beat == T_1) ? T_2 : (r_beat == T_2) ? T_3 : T_1;
         if (w_dec) begin
            w_w_nxt   = next_w(r_w, short, long);
            w_run_nxt = !w_halt;
         end
      end
   end
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_w       <= W_1;
         r_beat    <= T_1;
         r_cnt     <= '0;
         r_running <= 1'b0;
      end else begin
         r_w       <= w_w_nxt;
         r_beat    <= w_beat_nxt;
         r_cnt     <= w_cnt_nxt;
         r_running <= w_run_nxt;
      end
   end
   assign w1      = r_w == W_1;
   assign w2      = r_w == W_2;
   assign w3      = r_w == W_3;
   assign t1      = r_running && r_beat == T_1;
   assign t2      = r_running && r_beat == T_2;
   assign t3      = r_running && r_beat == T_3;
   assign running = r_running;
endmodule
